// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory target with byte strobes and wait states
module dmem_responder #(
  parameter int          ram_depth   = 10,
  parameter logic [31:0] base_addr   = 32'h0000_0000,
  parameter int          wait_states = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_fence,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        err_addr,
  output logic        err_proto
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {CLS_LOAD, CLS_STORE, CLS_FENCE} cls_t;

  logic [31:0] ram [0:(1<<ram_depth)-1];

  state_t               state;
  cls_t                 req_cls;
  logic [3:0]           counter;
  logic [ram_depth-1:0] req_idx;
  logic [31:0]          req_wdata;
  logic [3:0]           req_wstrb;
  logic                 req_in_range;

  // 33-bit window compare so a window ending at 4 GiB cannot wrap
  logic [32:0] addr_ext, win_lo, win_hi;
  logic        in_range;
  logic        accept;
  logic        unused_bits;

  assign addr_ext    = {1'b0, mem_addr};
  assign win_lo      = {1'b0, base_addr};
  assign win_hi      = win_lo + (33'd1 << (ram_depth + 2));
  assign in_range    = (addr_ext >= win_lo) && (addr_ext < win_hi);
  assign accept      = mem_valid && ((state == IDLE) || (state == RESP));
  assign unused_bits = ^{mem_instr, mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      counter      <= 4'd0;
      mem_ready    <= 1'b0;
      mem_rdata    <= 32'd0;
      err_addr     <= 1'b0;
      err_proto    <= 1'b0;
      req_cls      <= CLS_LOAD;
      req_idx      <= '0;
      req_wdata    <= 32'd0;
      req_wstrb    <= 4'd0;
      req_in_range <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      case (state)
        IDLE: ;
        WAIT: begin
          if (mem_valid) err_proto <= 1'b1;
          if (counter == 4'd0) state <= ACCESS;
          else counter <= counter - 4'd1;
        end
        ACCESS: begin
          if (mem_valid) err_proto <= 1'b1;
          state     <= RESP;
          mem_ready <= 1'b1;
          if (req_cls == CLS_LOAD && req_in_range) mem_rdata <= ram[req_idx];
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // capture overrides the RESP->IDLE return for back-to-back requests
      if (accept) begin
        state        <= WAIT;
        counter      <= 4'(wait_states);
        req_idx      <= mem_addr[ram_depth+1:2];
        req_wdata    <= mem_wdata;
        req_wstrb    <= mem_wstrb;
        req_in_range <= in_range;
        if (mem_fence)       req_cls <= CLS_FENCE;
        else if (|mem_wstrb) req_cls <= CLS_STORE;
        else                 req_cls <= CLS_LOAD;
        if (!in_range && !mem_fence) err_addr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && state == ACCESS && req_cls == CLS_STORE && req_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) ram[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_fence = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr  = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        err_addr;
  logic        err_proto;

  int tests = 0;
  int fails = 0;

  dmem_responder #(.ram_depth(10), .base_addr(32'h0), .wait_states(2)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_fence(mem_fence),
    .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err_addr(err_addr), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic f);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_fence = f;
  endtask

  // Called at the negedge right after the valid edge; latency counts edges after it.
  task automatic wait_ready(output int lat, output logic [31:0] rd);
    int k = 1;
    lat = 99;
    rd  = 32'hxxxx_xxxx;
    while (k < 40 && !mem_ready) begin
      @(negedge clk);
      k++;
    end
    if (mem_ready) begin
      lat = k - 1;
      rd  = mem_rdata;
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic f, output int lat, output logic [31:0] rd);
    @(negedge clk);
    drive(a, d, s, f);
    @(negedge clk);
    mem_valid = 1'b0; mem_fence = 1'b0;
    wait_ready(lat, rd);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", mem_ready); end
    tests++; if (mem_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
    tests++; if (err_addr !== 1'b0) begin fails++; $display("FAIL reset_err_addr got %b want 0", err_addr); end
    tests++; if (err_proto !== 1'b0) begin fails++; $display("FAIL reset_err_proto got %b want 0", err_proto); end
    rst = 1'b1;
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rd;
    do_req(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, rd);
    tests++; if (lat !== 4) begin fails++; $display("FAIL store_latency got %0d want 4", lat); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL store_rdata got %h want 0", rd); end
    do_req(32'h10, 32'h0, 4'h0, 1'b0, lat, rd);
    tests++; if (lat !== 4) begin fails++; $display("FAIL load_latency got %0d want 4", lat); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL load_rdata got %h want deadbeef", rd); end
  endtask

  task automatic test_partial_store;
    int lat; logic [31:0] rd;
    do_req(32'h20, 32'h11223344, 4'hF, 1'b0, lat, rd);
    do_req(32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, lat, rd);
    do_req(32'h22, 32'h0, 4'h0, 1'b0, lat, rd);
    tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL partial_rdata got %h want 11bb33dd", rd); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd;
    do_req(32'h14, 32'hCAFEF00D, 4'hF, 1'b0, lat, rd);
    tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL b2b_store_ready got %b want 1", mem_ready); end
    drive(32'h14, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    mem_valid = 1'b0;
    wait_ready(lat, rd);
    tests++; if (lat !== 4) begin fails++; $display("FAIL b2b_latency got %0d want 4", lat); end
    tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL b2b_rdata got %h want cafef00d", rd); end
    tests++; if (err_proto !== 1'b0) begin fails++; $display("FAIL b2b_err_proto got %b want 0", err_proto); end
  endtask

  task automatic test_fence_oor;
    int lat; logic [31:0] rd;
    do_req(32'h0, 32'h5A5A5A5A, 4'hF, 1'b0, lat, rd);
    do_req(32'h0, 32'hFFFFFFFF, 4'hF, 1'b1, lat, rd);
    tests++; if (lat !== 4) begin fails++; $display("FAIL fence_latency got %0d want 4", lat); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL fence_rdata got %h want 0", rd); end
    tests++; if (err_addr !== 1'b0) begin fails++; $display("FAIL fence_err_addr got %b want 0", err_addr); end
    do_req(32'h1000, 32'h12345678, 4'hF, 1'b0, lat, rd);
    tests++; if (lat !== 4) begin fails++; $display("FAIL oor_latency got %0d want 4", lat); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL oor_rdata got %h want 0", rd); end
    tests++; if (err_addr !== 1'b1) begin fails++; $display("FAIL oor_err_addr got %b want 1", err_addr); end
    do_req(32'h0, 32'h0, 4'h0, 1'b0, lat, rd);
    tests++; if (rd !== 32'h5A5A5A5A) begin fails++; $display("FAIL fence_ram_word0 got %h want 5a5a5a5a", rd); end
    do_req(32'h1000, 32'h0, 4'h0, 1'b0, lat, rd);
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL oor_load got %h want 0", rd); end
  endtask

  task automatic test_violation;
    int pulses = 0; logic [31:0] rd = 32'd0;
    @(negedge clk);
    drive(32'h10, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    drive(32'h20, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    mem_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ready) begin pulses++; rd = mem_rdata; end
    end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL viol_pulses got %0d want 1", pulses); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL viol_rdata got %h want deadbeef", rd); end
    tests++; if (err_proto !== 1'b1) begin fails++; $display("FAIL viol_err_proto got %b want 1", err_proto); end
  endtask

  task automatic test_reset_mid;
    int lat; int pulses = 0; logic [31:0] rd;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    do_req(32'h30, 32'h0, 4'hF, 1'b0, lat, rd);
    @(negedge clk);
    drive(32'h30, 32'hFFFFFFFF, 4'hF, 1'b0);
    @(negedge clk);
    mem_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL rstmid_pulses got %0d want 0", pulses); end
    tests++; if (err_addr !== 1'b0 || err_proto !== 1'b0) begin fails++; $display("FAIL rstmid_errs got %b%b want 00", err_addr, err_proto); end
    do_req(32'h30, 32'h0, 4'h0, 1'b0, lat, rd);
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rstmid_word got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial_store();
    test_back_to_back();
    test_fence_oor();
    test_violation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
